// File: rtl/debug_send_sequencer.sv
// debug_send_sequencer: serializes a pipeline snapshot (PC, cycle count,
// register file, optionally data memory) MSB-first over the UART TX
// start/done handshake, one byte at a time.
// Optional feature: define DBG_SEND_MEM_EN to append the data-memory dump.
module debug_send_sequencer #(
    parameter int NB_DATA     = 32,
    parameter int N_REGS      = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_MEM_WORDS = 32,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_clk_count,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    // One extra bit so the last-word compare can never wrap.
    localparam int NB_WIDX = ((NB_REG_ADDR > NB_MEM_ADDR) ? NB_REG_ADDR : NB_MEM_ADDR) + 1;
    localparam logic [NB_WIDX-1:0] LAST_REG = NB_WIDX'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_COUNT,
        SEC_REGS,
        SEC_MEM
    } section_t;

    state_t                 state_q, state_d;
    section_t               section_q, section_d;
    logic [NB_WIDX-1:0]     word_idx_q, word_idx_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [NB_DATA-1:0]     word_buf_q, word_buf_d;
    logic [NB_DATA-1:0]     pc_snap_q, pc_snap_d;
    logic [NB_DATA-1:0]     cnt_snap_q, cnt_snap_d;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic                   active_d;

`ifdef DBG_SEND_MEM_EN
    localparam logic [NB_WIDX-1:0] LAST_MEM = NB_WIDX'(N_MEM_WORDS - 1);
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
`else
    logic unused_mem;
    assign unused_mem = ^{i_mem_data, 32'(N_MEM_WORDS)};
`endif

    // Next-state, datapath and read-address computation.
    always_comb begin
        state_d    = state_q;
        section_d  = section_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        pc_snap_d  = pc_snap_q;
        cnt_snap_d = cnt_snap_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pc_snap_d  = i_pc;
                    cnt_snap_d = i_clk_count;
                    section_d  = SEC_PC;
                    word_idx_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                case (section_q)
                    SEC_PC:    word_buf_d = pc_snap_q;
                    SEC_COUNT: word_buf_d = cnt_snap_q;
                    SEC_REGS:  word_buf_d = i_reg_data;
`ifdef DBG_SEND_MEM_EN
                    SEC_MEM:   word_buf_d = i_mem_data;
`else
                    SEC_MEM:   word_buf_d = '0;
`endif
                    default:   word_buf_d = '0;
                endcase
                byte_idx_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    word_buf_d = {word_buf_q[NB_DATA-9:0], 8'h00};
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = (byte_idx_q == 2'd3) ? ST_ADVANCE : ST_SEND;
                end
            end
            ST_ADVANCE: begin
                state_d = ST_FETCH;
                case (section_q)
                    SEC_PC: begin
                        section_d  = SEC_COUNT;
                        word_idx_d = '0;
                    end
                    SEC_COUNT: begin
                        section_d  = SEC_REGS;
                        word_idx_d = '0;
                    end
                    SEC_REGS: begin
                        if (word_idx_q == LAST_REG) begin
`ifdef DBG_SEND_MEM_EN
                            section_d  = SEC_MEM;
                            word_idx_d = '0;
`else
                            state_d    = ST_DONE;
`endif
                        end else begin
                            word_idx_d = word_idx_q + NB_WIDX'(1);
                        end
                    end
                    SEC_MEM: begin
`ifdef DBG_SEND_MEM_EN
                        if (word_idx_q == LAST_MEM) begin
                            state_d = ST_DONE;
                        end else begin
                            word_idx_d = word_idx_q + NB_WIDX'(1);
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Addresses are registered from next-state values so they are
        // already stable during FETCH; 0 whenever their section is idle.
        active_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        reg_addr_d = (active_d && section_d == SEC_REGS) ? word_idx_d[NB_REG_ADDR-1:0] : '0;
`ifdef DBG_SEND_MEM_EN
        mem_addr_d = (active_d && section_d == SEC_MEM) ? word_idx_d[NB_MEM_ADDR-1:0] : '0;
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            section_q  <= SEC_PC;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            pc_snap_q  <= '0;
            cnt_snap_q <= '0;
            reg_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            section_q  <= section_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            pc_snap_q  <= pc_snap_d;
            cnt_snap_q <= cnt_snap_d;
            reg_addr_q <= reg_addr_d;
        end
    end

`ifdef DBG_SEND_MEM_EN
    // Memory read-address register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr_q <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
        end
    end
    assign o_mem_addr = mem_addr_q;
`else
    assign o_mem_addr = '0;
`endif

    assign o_reg_addr = reg_addr_q;
    assign o_tx_data  = word_buf_q[NB_DATA-1 -: 8];
    assign o_tx_start = (state_q == ST_SEND);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_send_sequencer.sv
// Self-checking bench for debug_send_sequencer. Honors DBG_SEND_MEM_EN the
// same way the design does.
module tb_debug_send_sequencer;

    logic        clk, rst, i_start, i_tx_done;
    logic [31:0] i_pc, i_clk_count, i_reg_data, i_mem_data;
    logic [4:0]  o_reg_addr, o_mem_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start, o_busy, o_done;

    logic [31:0] regs [32];
    logic [31:0] mem  [32];
    logic [7:0]  got_q [$];
    int          checks = 0;
    int          errors = 0;

`ifdef DBG_SEND_MEM_EN
    localparam int FRAME = 8 + 4 * 32 + 4 * 32;
`else
    localparam int FRAME = 8 + 4 * 32;
`endif

    debug_send_sequencer #(
        .NB_DATA(32), .N_REGS(32), .NB_REG_ADDR(5), .N_MEM_WORDS(32), .NB_MEM_ADDR(5)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pc(i_pc), .i_clk_count(i_clk_count),
        .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
        .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Register file and data memory models: synchronous read, 1-cycle latency.
    always @(posedge clk) begin
        i_reg_data <= regs[o_reg_addr];
        i_mem_data <= mem[o_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_directed();
        for (int k = 0; k < 32; k++) begin
            regs[k] = 32'h100 + 32'(k);
            mem[k]  = 32'hA000 + 32'(k);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) begin
            regs[k] = $urandom;
            mem[k]  = $urandom;
        end
    endtask

    // One dump: byte stream compared with a frame built from the snapshot and
    // the memory contents; TX responder answers 'delay' cycles after each start.
    task automatic run_dump(input logic [31:0] pc, input logic [31:0] cnt, input int delay,
                            input int slow_byte, input int abort_byte, input bit noise);
        logic [31:0] words [$];
        logic [7:0]  exp_q [$];
        logic [31:0] w;
        logic [7:0]  held;
        int  idx, cd, last_done_cyc, cyc, abort_stage;
        bit  outstanding, all_done, finished, ob;
        idx = 0; cd = 0; last_done_cyc = 0; cyc = 0; abort_stage = 0;
        outstanding = 0; all_done = 0; finished = 0; held = '0;

        words.push_back(pc);
        words.push_back(cnt);
        for (int k = 0; k < 32; k++) words.push_back(regs[k]);
`ifdef DBG_SEND_MEM_EN
        for (int k = 0; k < 32; k++) words.push_back(mem[k]);
`endif
        foreach (words[i]) begin
            w = words[i];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
        got_q = {};

        @(negedge clk);
        check("idle_busy", o_busy, 0);
        check("idle_tx_start", o_tx_start, 0);
        check("idle_done", o_done, 0);
        i_pc = pc; i_clk_count = cnt; i_start = 1; i_tx_done = 0;

        while (!finished && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            i_start = 0; i_tx_done = 0;
            if (abort_stage == 2) begin
                check("abort_busy", o_busy, 0);
                check("abort_tx_start", o_tx_start, 0);
                check("abort_done", o_done, 0);
                rst = 1;
                finished = 1;
            end else begin
                if (abort_stage == 1) begin
                    rst = 0;
                    abort_stage = 2;
                end
                if (noise) begin
                    i_pc = (idx >= 4 && idx < 8) ? 32'hFFFF_FFFF : $urandom;
                    i_clk_count = $urandom;
                    if ($urandom_range(0, 19) == 0) i_start = 1;
                end
                ob = outstanding;
                if (ob) check("tx_data_hold", o_tx_data, held);
                check("no_start_while_waiting", o_tx_start && ob, 0);
                if (ob) begin
                    cd--;
                    if (cd == 0) begin
                        i_tx_done = 1;
                        outstanding = 0;
                        last_done_cyc = cyc;
                        if (idx == exp_q.size()) all_done = 1;
                    end
                end
                if (o_tx_start) begin
                    if (idx < exp_q.size()) check($sformatf("byte%0d", idx), o_tx_data, exp_q[idx]);
                    else check("byte_overflow", idx, exp_q.size());
                    if (idx == 0) check("first_start_latency", cyc, 3);
                    else check($sformatf("start_gap%0d", idx), cyc - last_done_cyc, (idx % 4 == 0) ? 4 : 1);
                    got_q.push_back(o_tx_data);
                    held = o_tx_data;
                    outstanding = 1;
                    cd = (idx == slow_byte) ? 1000 : delay;
                    if (idx == abort_byte) abort_stage = 1;
                    idx++;
                end
                if (noise && !ob && !i_tx_done && $urandom_range(0, 3) == 0) i_tx_done = 1;
                check("busy", o_busy, 1);
                check("done", o_done, (all_done && cyc == last_done_cyc + 2) ? 1 : 0);
`ifndef DBG_SEND_MEM_EN
                check("mem_addr_tied", o_mem_addr, 0);
`endif
                if (all_done && cyc == last_done_cyc + 2) finished = 1;
            end
        end
        check("dump_terminated", finished, 1);

        if (abort_byte >= 0) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                i_start = 0;
                i_tx_done = (k == 0);
                check("post_abort_tx_start", o_tx_start, 0);
                check("post_abort_done", o_done, 0);
                check("post_abort_busy", o_busy, 0);
            end
            i_tx_done = 0;
        end else begin
            check("byte_count", got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        logic [7:0] head [12];
        head = '{8'h00, 8'h40, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h01, 8'h00};

        rst = 0; i_start = 0; i_tx_done = 0; i_pc = '0; i_clk_count = '0;
        fill_directed();

        // Reset held three cycles; start/done pulses meanwhile must not matter.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_reg_addr", o_reg_addr, 0);
            check("rst_mem_addr", o_mem_addr, 0);
            check("rst_tx_data", o_tx_data, 0);
            check("rst_tx_start", o_tx_start, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            i_tx_done = (k == 1);
            i_start = (k == 0);
        end
        rst = 1; i_start = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_no_tx_start", o_tx_start, 0);
            check("idle_not_busy", o_busy, 0);
            i_tx_done = (k % 2 == 0);
        end
        i_tx_done = 0;

        // Directed full dump with the reference values.
        run_dump(32'h0040_0010, 32'h0000_002A, 5, -1, -1, 0);
        check("frame_len", got_q.size(), FRAME);
        if (got_q.size() == FRAME) begin
            for (int i = 0; i < 12; i++) check($sformatf("head%0d", i), got_q[i], head[i]);
`ifdef DBG_SEND_MEM_EN
            check("tail", {got_q[FRAME-4], got_q[FRAME-3], got_q[FRAME-2], got_q[FRAME-1]}, 32'h0000_A01F);
`else
            check("tail", {got_q[FRAME-4], got_q[FRAME-3], got_q[FRAME-2], got_q[FRAME-1]}, 32'h0000_011F);
`endif
        end

        // Same values with input churn, stray starts and stray tx_done pulses.
        run_dump(32'h0040_0010, 32'h0000_002A, 5, -1, -1, 1);

        // Random contents with one very slow byte.
        fill_random();
        run_dump($urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, FRAME - 1), -1, 1);

        // Abort while reg 5 byte 2 is in flight, then restart from the top.
        fill_directed();
        run_dump(32'h0040_0010, 32'h0000_002A, 5, -1, 8 + 5 * 4 + 2, 0);
        run_dump(32'h0040_0010, 32'h0000_002A, 3, -1, -1, 0);
        check("restart_first_byte", got_q.size() > 0 ? {24'h0, got_q[0]} : 32'hFFFF_FFFF, 32'h0);

        // Back-to-back random dumps.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_dump($urandom, $urandom, $urandom_range(1, 7), -1, -1, 1);
        end

        @(negedge clk);
        i_start = 0; i_tx_done = 0;
        check("final_idle_busy", o_busy, 0);
        check("final_idle_done", o_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
